sync_fifo_ctrl: RTL and testbench
=================================

Name: sync_fifo_ctrl

Overview:
- Single-clock FIFO with integrated storage, read/write pointers and occupancy counter.
- Generates full/empty, programmable almost-full/almost-empty and sticky overflow/underflow flags.
- Registered read port with an rd_valid strobe.
- Generalised successor to the standalone FIFO storage block: callers no longer supply addresses or flags.

Parameters:
- WIDTH, 4, data word width in bits (>=1).
- DEPTH, 8, number of entries; power of two, >=2.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  synchronous clear of contents; error flags kept.
- wr_rq  in  1  write request.
- wdata  in  WIDTH  write data.
- rd_rq  in  1  read request.
- rdata  out  WIDTH  registered read data.
- rd_valid  out  1  rdata updated this cycle (1-cycle pulse per accepted read).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.
- clr_err  in  1  clears overflow/underflow.

Behaviour:
- Reset (rst_n=0 at edge):
  - wptr, rptr, count, rdata, rd_valid, overflow, underflow = 0.
  - empty=1, almost_empty=1, full=0, almost_full=0.
  - Memory contents are not reset.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. count is tracked separately.
- All flags are registered and derived from the next-state count, so they are valid in the same cycle count changes.
- Write is accepted iff wr_rq && !full (registered full, no pass-through):
  - mem[wptr] <= wdata; wptr+1.
- Read is accepted iff rd_rq && !empty:
  - rdata <= mem[rptr]; rptr+1; rd_valid=1 next cycle.
  - Latency: data appears 1 cycle after the accepted rd_rq.
- No accepted read: rdata holds its last value and rd_valid=0.
- Simultaneous accepted read and write: both pointers advance and count is unchanged.
  - Empty + both requests: only the write is accepted (count 0->1). Read is rejected and underflow is set.
  - Full + both requests: only the read is accepted (count DEPTH->DEPTH-1). Write is rejected and overflow is set.
- Rejected write: memory and wptr unchanged.
- Rejected read: rdata and rptr unchanged.
- overflow is set on wr_rq && full; underflow is set on rd_rq && empty.
  - Cleared by clr_err=1.
  - If set and clear occur in the same cycle, set wins.
- flush=1 (with rst_n=1):
  - wptr, rptr, count = 0; flags take their empty values; rd_valid=0.
  - rdata and error flags are unchanged.
  - Overrides wr_rq/rd_rq that cycle: no access and no error flag set.
- Priority order: rst_n > flush > normal operation.
- Reset mid-burst drops all contents. Operation resumes the cycle after rst_n returns to 1.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, release -> empty=1, almost_empty=1, count=0, rdata=0, rd_valid=0.
- Fill/drain order (WIDTH=4, DEPTH=8):
  - Write 1..8 on consecutive cycles -> full=1 after 8th write, almost_full=1 from count=6.
  - Read 8 -> rdata 1..8, each 1 cycle after its rd_rq with rd_valid=1.
  - Ends with empty=1.
- Wrap-around: write 5, read 5, write 8 (A..H), read 8 -> data A..H in order, pointers wrapped, count=0 at end.
- Simultaneous ops:
  - At count=3, wr_rq=rd_rq=1 for 4 cycles -> count stays 3 and output order is preserved.
  - At count=0, both requests -> count=1, underflow=1.
  - At count=8, both requests -> count=7, overflow=1.
- Errors:
  - Write while full -> overflow=1, stored data unchanged; clr_err -> overflow=0.
  - clr_err with rd_rq on empty in the same cycle -> underflow=1 (set wins).
- Flush/reset mid-operation:
  - At count=5, flush with wr_rq=1 -> count=0, empty=1, overflow keeps its value.
  - A subsequent write of 9 then a read returns 9.
  - rst_n=0 at count=4 -> all outputs return to their reset values.

Source files
------------

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO: storage, wrapping pointers, occupancy counter, registered
// status flags, sticky error flags and a registered read port with rd_valid.
module sync_fifo_ctrl #(
    parameter int WIDTH    = 4,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     wr_rq,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     rd_rq,
    output logic [WIDTH-1:0]         rdata,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             wr_ok;
    logic             rd_ok;
    logic [CW-1:0]    count_next;

    // Handshake: wr_rq/rd_rq are single-cycle requests with no ready return.
    // A write is taken iff wr_rq && !full, a read iff rd_rq && !empty (both
    // using the registered flags); a refused request sets its sticky error.
    assign wr_ok = wr_rq && !full;
    assign rd_ok = rd_rq && !empty;

    always_comb begin
        count_next = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Storage has no reset; contents are only ever observed through rptr.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && wr_ok) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            rdata        <= '0;
            rd_valid     <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else if (flush) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            rd_valid     <= 1'b0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + AW'(1);
            end
            if (rd_ok) begin
                rptr  <= rptr + AW'(1);
                rdata <= mem[rptr];
            end
            rd_valid     <= rd_ok;
            count        <= count_next;
            // Flags follow the next-state count so they move with count.
            full         <= (count_next == FULL_CNT);
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= AF_CNT);
            almost_empty <= (count_next <= AE_CNT);
            if (wr_rq && full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rd_rq && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl (WIDTH=4, DEPTH=8): each task drives one
// scenario and checks its own expected values.
module tb_sync_fifo_ctrl;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       wr_rq;
    logic [3:0] wdata;
    logic       rd_rq;
    logic [3:0] rdata;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;
    logic       clr_err;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp_d;

    sync_fifo_ctrl #(.WIDTH(4), .DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_rq(wr_rq), .wdata(wdata),
        .rd_rq(rd_rq), .rdata(rdata), .rd_valid(rd_valid), .full(full),
        .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow),
        .clr_err(clr_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] d);
        wr_rq = 1'b1;
        wdata = d;
        cyc();
        wr_rq = 1'b0;
        exp_q.push_back(d);
    endtask

    task automatic do_read();
        rd_rq = 1'b1;
        cyc();
        rd_rq = 1'b0;
    endtask

    task automatic do_clr();
        clr_err = 1'b1;
        cyc();
        clr_err = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        vec_cnt++; if (empty !== 1'b1) begin err_cnt++; $display("FAIL reset_empty: got %b want 1", empty); end
        vec_cnt++; if (almost_empty !== 1'b1) begin err_cnt++; $display("FAIL reset_almost_empty: got %b want 1", almost_empty); end
        vec_cnt++; if (count !== 4'd0) begin err_cnt++; $display("FAIL reset_count: got %0d want 0", count); end
        vec_cnt++; if (rdata !== 4'h0) begin err_cnt++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        vec_cnt++; if (rd_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        vec_cnt++; if ({full, almost_full, overflow, underflow} !== 4'b0000) begin
            err_cnt++; $display("FAIL reset_flags: got %b want 0000", {full, almost_full, overflow, underflow}); end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 8; i++) begin
            do_write(4'(i));
            vec_cnt++; if (count !== 4'(i)) begin err_cnt++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i); end
            vec_cnt++; if (almost_full !== (i >= 6)) begin err_cnt++; $display("FAIL fill_almost_full[%0d]: got %b want %b", i, almost_full, i >= 6); end
            vec_cnt++; if (almost_empty !== (i <= 1)) begin err_cnt++; $display("FAIL fill_almost_empty[%0d]: got %b want %b", i, almost_empty, i <= 1); end
            vec_cnt++; if (full !== (i == 8)) begin err_cnt++; $display("FAIL fill_full[%0d]: got %b want %b", i, full, i == 8); end
            vec_cnt++; if (empty !== 1'b0) begin err_cnt++; $display("FAIL fill_empty[%0d]: got %b want 0", i, empty); end
        end
        for (int i = 1; i <= 8; i++) begin
            do_read();
            exp_d = exp_q.pop_front();
            vec_cnt++; if (rd_valid !== 1'b1) begin err_cnt++; $display("FAIL drain_rd_valid[%0d]: got %b want 1", i, rd_valid); end
            vec_cnt++; if (rdata !== exp_d) begin err_cnt++; $display("FAIL drain_rdata[%0d]: got %h want %h", i, rdata, exp_d); end
            vec_cnt++; if (count !== 4'(8 - i)) begin err_cnt++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, count, 8 - i); end
        end
        vec_cnt++; if (empty !== 1'b1) begin err_cnt++; $display("FAIL drain_empty: got %b want 1", empty); end
        cyc();
        vec_cnt++; if (rd_valid !== 1'b0) begin err_cnt++; $display("FAIL idle_rd_valid: got %b want 0", rd_valid); end
        vec_cnt++; if (rdata !== 4'h8) begin err_cnt++; $display("FAIL idle_rdata_hold: got %h want 8", rdata); end
    endtask

    task automatic test_wrap();
        logic [3:0] pat [8];
        pat = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1};
        for (int i = 0; i < 5; i++) do_write(4'(i + 3));
        for (int i = 0; i < 5; i++) begin
            do_read();
            exp_d = exp_q.pop_front();
            vec_cnt++; if (rdata !== exp_d) begin err_cnt++; $display("FAIL wrap_pre_rdata[%0d]: got %h want %h", i, rdata, exp_d); end
        end
        for (int i = 0; i < 8; i++) do_write(pat[i]);
        vec_cnt++; if (full !== 1'b1) begin err_cnt++; $display("FAIL wrap_full: got %b want 1", full); end
        for (int i = 0; i < 8; i++) begin
            do_read();
            exp_d = exp_q.pop_front();
            vec_cnt++; if (rdata !== exp_d || rd_valid !== 1'b1) begin
                err_cnt++; $display("FAIL wrap_rdata[%0d]: got %h/%b want %h/1", i, rdata, rd_valid, exp_d); end
        end
        vec_cnt++; if (count !== 4'd0) begin err_cnt++; $display("FAIL wrap_count: got %0d want 0", count); end
    endtask

    task automatic test_simultaneous();
        do_write(4'h2);
        do_write(4'h4);
        do_write(4'h6);
        for (int i = 0; i < 4; i++) begin
            wr_rq = 1'b1;
            rd_rq = 1'b1;
            wdata = 4'(i + 7);
            exp_q.push_back(4'(i + 7));
            cyc();
            exp_d = exp_q.pop_front();
            vec_cnt++; if (count !== 4'd3) begin err_cnt++; $display("FAIL simul_count[%0d]: got %0d want 3", i, count); end
            vec_cnt++; if (rdata !== exp_d || rd_valid !== 1'b1) begin
                err_cnt++; $display("FAIL simul_rdata[%0d]: got %h/%b want %h/1", i, rdata, rd_valid, exp_d); end
        end
        wr_rq = 1'b0;
        rd_rq = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_read();
            exp_d = exp_q.pop_front();
            vec_cnt++; if (rdata !== exp_d) begin err_cnt++; $display("FAIL simul_drain[%0d]: got %h want %h", i, rdata, exp_d); end
        end
        // both requests while empty: only the write goes in
        wr_rq = 1'b1; rd_rq = 1'b1; wdata = 4'h5;
        cyc();
        wr_rq = 1'b0; rd_rq = 1'b0;
        exp_q.push_back(4'h5);
        vec_cnt++; if (count !== 4'd1) begin err_cnt++; $display("FAIL simul_empty_count: got %0d want 1", count); end
        vec_cnt++; if (underflow !== 1'b1) begin err_cnt++; $display("FAIL simul_empty_underflow: got %b want 1", underflow); end
        vec_cnt++; if (rd_valid !== 1'b0) begin err_cnt++; $display("FAIL simul_empty_rd_valid: got %b want 0", rd_valid); end
        do_clr();
        vec_cnt++; if (underflow !== 1'b0) begin err_cnt++; $display("FAIL simul_clr_underflow: got %b want 0", underflow); end
        for (int i = 0; i < 7; i++) do_write(4'(8 - i));
        // both requests while full: only the read goes out
        wr_rq = 1'b1; rd_rq = 1'b1; wdata = 4'hF;
        cyc();
        wr_rq = 1'b0; rd_rq = 1'b0;
        exp_d = exp_q.pop_front();
        vec_cnt++; if (count !== 4'd7) begin err_cnt++; $display("FAIL simul_full_count: got %0d want 7", count); end
        vec_cnt++; if (overflow !== 1'b1) begin err_cnt++; $display("FAIL simul_full_overflow: got %b want 1", overflow); end
        vec_cnt++; if (rdata !== exp_d || rd_valid !== 1'b1) begin
            err_cnt++; $display("FAIL simul_full_rdata: got %h/%b want %h/1", rdata, rd_valid, exp_d); end
        for (int i = 0; i < 7; i++) begin
            do_read();
            exp_d = exp_q.pop_front();
            vec_cnt++; if (rdata !== exp_d) begin err_cnt++; $display("FAIL simul_full_drain[%0d]: got %h want %h", i, rdata, exp_d); end
        end
        do_clr();
    endtask

    task automatic test_errors();
        for (int i = 0; i < 8; i++) do_write(4'(i + 4));
        wr_rq = 1'b1; wdata = 4'hF;
        cyc();
        wr_rq = 1'b0;
        vec_cnt++; if (overflow !== 1'b1) begin err_cnt++; $display("FAIL err_overflow: got %b want 1", overflow); end
        vec_cnt++; if (count !== 4'd8) begin err_cnt++; $display("FAIL err_full_count: got %0d want 8", count); end
        do_clr();
        vec_cnt++; if (overflow !== 1'b0) begin err_cnt++; $display("FAIL err_clr_overflow: got %b want 0", overflow); end
        for (int i = 0; i < 8; i++) begin
            do_read();
            exp_d = exp_q.pop_front();
            vec_cnt++; if (rdata !== exp_d) begin err_cnt++; $display("FAIL err_data_kept[%0d]: got %h want %h", i, rdata, exp_d); end
        end
        // set and clear in the same cycle: set must win
        rd_rq = 1'b1; clr_err = 1'b1;
        cyc();
        rd_rq = 1'b0; clr_err = 1'b0;
        vec_cnt++; if (underflow !== 1'b1) begin err_cnt++; $display("FAIL err_set_wins: got %b want 1", underflow); end
        vec_cnt++; if (rd_valid !== 1'b0) begin err_cnt++; $display("FAIL err_empty_rd_valid: got %b want 0", rd_valid); end
        do_clr();
        vec_cnt++; if (underflow !== 1'b0) begin err_cnt++; $display("FAIL err_clr_underflow: got %b want 0", underflow); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 8; i++) do_write(4'(i + 1));
        wr_rq = 1'b1; wdata = 4'hF;
        cyc();
        wr_rq = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_read();
            exp_d = exp_q.pop_front();
        end
        vec_cnt++; if (count !== 4'd5) begin err_cnt++; $display("FAIL flush_pre_count: got %0d want 5", count); end
        flush = 1'b1; wr_rq = 1'b1; wdata = 4'hE;
        cyc();
        flush = 1'b0; wr_rq = 1'b0;
        exp_q.delete();
        vec_cnt++; if (count !== 4'd0) begin err_cnt++; $display("FAIL flush_count: got %0d want 0", count); end
        vec_cnt++; if ({empty, almost_empty, full, almost_full} !== 4'b1100) begin
            err_cnt++; $display("FAIL flush_flags: got %b want 1100", {empty, almost_empty, full, almost_full}); end
        vec_cnt++; if (overflow !== 1'b1) begin err_cnt++; $display("FAIL flush_overflow_kept: got %b want 1", overflow); end
        vec_cnt++; if (rdata !== 4'h3) begin err_cnt++; $display("FAIL flush_rdata_kept: got %h want 3", rdata); end
        vec_cnt++; if (rd_valid !== 1'b0) begin err_cnt++; $display("FAIL flush_rd_valid: got %b want 0", rd_valid); end
        do_write(4'h9);
        do_read();
        exp_d = exp_q.pop_front();
        vec_cnt++; if (rdata !== 4'h9 || rd_valid !== 1'b1) begin
            err_cnt++; $display("FAIL flush_after_rdata: got %h/%b want 9/1", rdata, rd_valid); end
        do_clr();
    endtask

    task automatic test_reset_mid();
        do_read();
        vec_cnt++; if (underflow !== 1'b1) begin err_cnt++; $display("FAIL rst_pre_underflow: got %b want 1", underflow); end
        for (int i = 0; i < 4; i++) do_write(4'(i + 10));
        vec_cnt++; if (count !== 4'd4) begin err_cnt++; $display("FAIL rst_pre_count: got %0d want 4", count); end
        rst_n = 1'b0; wr_rq = 1'b1; wdata = 4'h7;
        cyc();
        rst_n = 1'b1; wr_rq = 1'b0;
        exp_q.delete();
        vec_cnt++; if (count !== 4'd0) begin err_cnt++; $display("FAIL rst_mid_count: got %0d want 0", count); end
        vec_cnt++; if ({empty, almost_empty, full, almost_full} !== 4'b1100) begin
            err_cnt++; $display("FAIL rst_mid_flags: got %b want 1100", {empty, almost_empty, full, almost_full}); end
        vec_cnt++; if ({rd_valid, overflow, underflow} !== 3'b000) begin
            err_cnt++; $display("FAIL rst_mid_status: got %b want 000", {rd_valid, overflow, underflow}); end
        vec_cnt++; if (rdata !== 4'h0) begin err_cnt++; $display("FAIL rst_mid_rdata: got %h want 0", rdata); end
        do_write(4'h6);
        do_read();
        exp_d = exp_q.pop_front();
        vec_cnt++; if (rdata !== exp_d || count !== 4'd0) begin
            err_cnt++; $display("FAIL rst_resume: got %h/%0d want %h/0", rdata, count, exp_d); end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; wr_rq = 1'b0; rd_rq = 1'b0;
        wdata = 4'h0; clr_err = 1'b0;
        test_reset();
        test_fill_drain();
        test_wrap();
        test_simultaneous();
        test_errors();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
